// File: rtl/xhost_bridge_pkg.sv
// -----------------------------------------------------------------------------
// xhost_bridge_pkg
// Shared definitions for the host command bridge: frame opcodes, FSM state
// encoding, default word/address widths and the bytes-per-word derivation.
// No ports (package).
// -----------------------------------------------------------------------------
package xhost_bridge_pkg;

  // Default widths matching the processor register file
  localparam int XH_DATA_W      = 32;
  localparam int XH_REGF_ADDR_W = 4;

  // Frame opcodes (ASCII 'W', 'R', 'S')
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] OP_ST = 8'h53;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WRITE = 3'd3,
    S_RWAIT = 3'd4,
    S_RCAP  = 3'd5,
    S_TX    = 3'd6
  } state_e;

  // Bytes per register-file word
  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/xhost_txser.sv
// -----------------------------------------------------------------------------
// xhost_txser
// Parallel-load byte serializer. A load captures a word and a byte count;
// bytes are then presented LSB first on a registered valid/data pair and
// shifted out one per handshake. Used for read and status responses.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           load i_data/i_count (only issued while idle)
//   i_data           word to serialize
//   i_count          number of bytes to send (0 = nothing)
//   i_tx_ready       sink ready
//   o_tx_data        current byte (registered)
//   o_tx_valid       byte valid (registered)
//   o_last           handshake of the final byte is happening this cycle
// -----------------------------------------------------------------------------
module xhost_txser #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  output logic              o_last
);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic              w_hs;

  assign w_hs   = r_valid & i_tx_ready;
  assign o_last = w_hs & (r_count == CNT_W'(1));

  // Shift register, remaining-byte counter and valid flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_count <= i_count;
      r_valid <= (i_count != '0);
    end else if (w_hs) begin
      // Data only moves on a handshake, so it holds steady under backpressure
      r_shift <= r_shift >> 8;
      r_count <= r_count - CNT_W'(1);
      r_valid <= (r_count != CNT_W'(1));
    end
  end

  assign o_tx_data  = r_shift[7:0];
  assign o_tx_valid = r_valid;

endmodule

// File: rtl/xhost_bridge.sv
// -----------------------------------------------------------------------------
// xhost_bridge
// Host-side command bridge in front of the processor register-file port.
// Parses a byte stream (write 'W' addr d0..dN-1, read 'R' addr, status 'S')
// into register-file writes/reads and returns read data / trap status as a
// byte stream. rx and tx never overlap.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   rx_data/valid/ready   command byte stream in
//   tx_data/valid/ready   response byte stream out
//   par_addr/we/in/out    register-file port
//   trap                  processor trap flag (reported by status frame)
//   busy                  frame in progress
//   err                   one-cycle pulse on an illegal opcode
// -----------------------------------------------------------------------------
module xhost_bridge
  import xhost_bridge_pkg::*;
#(
  parameter int DATA_W      = XH_DATA_W,
  parameter int REGF_ADDR_W = XH_REGF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [REGF_ADDR_W-1:0] par_addr,
  output logic                   par_we,
  output logic [DATA_W-1:0]      par_in,
  input  logic [DATA_W-1:0]      par_out,
  input  logic                   trap,
  output logic                   busy,
  output logic                   err
);

  localparam int NB    = nb_of(DATA_W);
  localparam int CNT_W = $clog2(NB + 1);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [7:0]             r_opcode;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic [REGF_ADDR_W-1:0] r_par_addr;
  logic [DATA_W-1:0]      r_par_in;
  logic                   r_par_we;
  logic                   r_busy;
  logic                   r_err;
  logic                   r_rx_ready;

  logic                   w_accept;
  logic                   w_ld;
  logic [DATA_W-1:0]      w_ld_data;
  logic [CNT_W-1:0]       w_ld_cnt;
  logic                   w_err;
  logic                   w_latch_op;
  logic                   w_latch_addr;
  logic                   w_wr_byte;
  logic                   w_tx_last;

  assign w_accept = rx_valid & r_rx_ready;

  // Next-state and datapath control decode
  always_comb begin
    w_next_state = r_state;
    w_ld         = 1'b0;
    w_ld_data    = '0;
    w_ld_cnt     = '0;
    w_err        = 1'b0;
    w_latch_op   = 1'b0;
    w_latch_addr = 1'b0;
    w_wr_byte    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (rx_data)
            OP_WR, OP_RD: begin
              w_latch_op   = 1'b1;
              w_next_state = S_ADDR;
            end
            OP_ST: begin
              // Trap is sampled in the accept cycle; response is {7'b0, trap}
              w_ld         = 1'b1;
              w_ld_data    = DATA_W'(trap);
              w_ld_cnt     = CNT_W'(1);
              w_next_state = S_TX;
            end
            default: begin
              w_err        = 1'b1;
              w_next_state = S_IDLE;
            end
          endcase
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADDR: begin
        if (w_accept) begin
          w_latch_addr = 1'b1;
          if (r_opcode == OP_WR) begin
            w_next_state = S_WDATA;
          end else begin
            w_next_state = S_RWAIT;
          end
        end else begin
          w_next_state = S_ADDR;
        end
      end
      S_WDATA: begin
        if (w_accept) begin
          w_wr_byte = 1'b1;
          if (r_byte_cnt == CNT_W'(NB - 1)) begin
            w_next_state = S_WRITE;
          end else begin
            w_next_state = S_WDATA;
          end
        end else begin
          w_next_state = S_WDATA;
        end
      end
      S_WRITE: w_next_state = S_IDLE;
      // One settle cycle so a registered register file has its data ready
      S_RWAIT: w_next_state = S_RCAP;
      S_RCAP: begin
        w_ld         = 1'b1;
        w_ld_data    = par_out;
        w_ld_cnt     = CNT_W'(NB);
        w_next_state = S_TX;
      end
      S_TX: begin
        if (w_tx_last) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_TX;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Opcode, address and write-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opcode   <= 8'h00;
      r_byte_cnt <= '0;
      r_par_addr <= '0;
      r_par_in   <= '0;
    end else begin
      if (w_latch_op) begin
        r_opcode <= rx_data;
      end
      if (w_latch_addr) begin
        r_par_addr <= rx_data[REGF_ADDR_W-1:0];
        r_byte_cnt <= '0;
      end
      if (w_wr_byte) begin
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
      // Little-endian byte lanes
      for (int b = 0; b < NB; b++) begin
        if (w_wr_byte && (r_byte_cnt == CNT_W'(b))) begin
          r_par_in[8*b +: 8] <= rx_data;
        end
      end
    end
  end

  // Registered status/strobe outputs, decoded from the next state so they
  // line up with the state they describe. rx_ready stays low while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_rx_ready <= 1'b0;
    end else begin
      r_par_we   <= (w_next_state == S_WRITE);
      r_busy     <= (w_next_state != S_IDLE);
      r_err      <= w_err;
      r_rx_ready <= (w_next_state == S_IDLE) || (w_next_state == S_ADDR) ||
                    (w_next_state == S_WDATA);
    end
  end

  xhost_txser #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_txser (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_ld),
    .i_data     (w_ld_data),
    .i_count    (w_ld_cnt),
    .i_tx_ready (tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_last     (w_tx_last)
  );

  assign rx_ready = r_rx_ready;
  assign par_addr = r_par_addr;
  assign par_in   = r_par_in;
  assign par_we   = r_par_we;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_xhost_bridge.sv
// -----------------------------------------------------------------------------
// tb_xhost_bridge
// Self-checking bench for xhost_bridge: directed frames plus randomized
// frames, rx gaps and tx backpressure, checked against a frame-level model
// (expected write queue, expected tx byte queue, model register memory).
// -----------------------------------------------------------------------------
module tb_xhost_bridge;

  localparam int DATA_W      = 32;
  localparam int REGF_ADDR_W = 4;
  localparam int NB          = DATA_W / 8;

  localparam logic [31:0] INIT [16] = '{
    32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0,
    32'h0F1E2D3C, 32'hDEADBEEF, 32'hCAFEF00D, 32'h55AA33CC,
    32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000,
    32'h80000001, 32'h7FFFFFFE, 32'h10203040, 32'hFEDCBA98
  };

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [7:0]             rx_data = 8'h00;
  logic                   rx_valid = 1'b0;
  logic                   rx_ready;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready = 1'b1;
  logic [REGF_ADDR_W-1:0] par_addr;
  logic                   par_we;
  logic [DATA_W-1:0]      par_in;
  logic [DATA_W-1:0]      par_out;
  logic                   trap = 1'b0;
  logic                   busy;
  logic                   err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  int seen_err = 0;
  int tx_mode  = 0;
  int stall_cnt = 0;
  logic       prev_pending = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [31:0] regf [16] = INIT;
  logic [31:0] mdl_mem [16];
  logic [7:0]  exp_tx_q [$];
  logic [35:0] exp_wr_q [$];

  xhost_bridge #(
    .DATA_W      (DATA_W),
    .REGF_ADDR_W (REGF_ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .par_addr (par_addr),
    .par_we   (par_we),
    .par_in   (par_in),
    .par_out  (par_out),
    .trap     (trap),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Environment register file: combinational read, write on strobe
  assign par_out = regf[par_addr];
  always @(posedge clk) begin
    if (par_we) regf[par_addr] <= par_in;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and tx_ready driver, all on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_pending = 1'b0;
      end else begin
        if (prev_pending) begin
          check_val("tx_hold_valid", 64'(tx_valid), 64'd1);
          check_val("tx_hold_data", 64'(tx_data), 64'(prev_data));
        end
        case (tx_mode)
          0: tx_ready = 1'b1;
          1: tx_ready = ~tx_ready;
          default: begin
            if (stall_cnt > 0) begin
              tx_ready = 1'b0;
              stall_cnt--;
            end else if ($urandom_range(0, 4) == 0) begin
              tx_ready = 1'b0;
              stall_cnt = 2;
            end else begin
              tx_ready = ~tx_ready;
            end
          end
        endcase
        if (tx_valid && tx_ready) begin
          if (exp_tx_q.size() == 0) begin
            check_val("tx_byte_pending", 64'(exp_tx_q.size()), 64'd1);
          end else begin
            check_val("tx_byte", 64'(tx_data), 64'(exp_tx_q.pop_front()));
          end
        end
        prev_pending = tx_valid && !tx_ready;
        prev_data    = tx_data;
        if (par_we) begin
          if (exp_wr_q.size() == 0) begin
            check_val("par_we_pending", 64'(exp_wr_q.size()), 64'd1);
          end else begin
            logic [35:0] e;
            e = exp_wr_q.pop_front();
            check_val("par_we_addr", 64'(par_addr), 64'(e[35:32]));
            check_val("par_we_data", 64'(par_in), 64'(e[31:0]));
          end
        end
        if (err) seen_err++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic r;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      r = rx_ready;
      @(negedge clk);
      n++;
      if (r) break;
      if (n > 2000) begin
        check_val("rx_accept_timeout", 64'(r), 64'd1);
        break;
      end
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_tx_done();
    int n;
    n = 0;
    while (exp_tx_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_drained", 64'(exp_tx_q.size()), 64'd0);
    @(negedge clk);
    check_val("busy_after_tx", 64'(busy), 64'd0);
    check_val("tx_valid_after_tx", 64'(tx_valid), 64'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int gap);
    exp_wr_q.push_back({a[3:0], d});
    mdl_mem[a[3:0]] = d;
    send_byte(8'h57);
    idle_cycles(gap);
    send_byte(a);
    for (int i = 0; i < NB; i++) begin
      idle_cycles(gap);
      send_byte(d[8*i +: 8]);
    end
    check_val("we_latency", 64'(par_we), 64'd1);
    @(negedge clk);
    check_val("we_pulse_end", 64'(par_we), 64'd0);
    check_val("busy_after_wr", 64'(busy), 64'd0);
    @(negedge clk);
    check_val("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    logic [31:0] w;
    w = mdl_mem[a[3:0]];
    for (int i = 0; i < NB; i++) exp_tx_q.push_back(w[8*i +: 8]);
    send_byte(8'h52);
    idle_cycles(gap);
    send_byte(a);
    check_val("rd_lat_c1", 64'(tx_valid), 64'd0);
    @(negedge clk);
    check_val("rd_lat_c2", 64'(tx_valid), 64'd0);
    @(negedge clk);
    check_val("rd_lat_c3", 64'(tx_valid), 64'd1);
    wait_tx_done();
  endtask

  task automatic do_status(input logic tv);
    trap = tv;
    exp_tx_q.push_back({7'b0, tv});
    send_byte(8'h53);
    trap = ~tv;
    wait_tx_done();
  endtask

  task automatic do_illegal(input logic [7:0] b);
    exp_err++;
    send_byte(b);
    idle_cycles(2);
    check_val("err_count", 64'(seen_err), 64'(exp_err));
    check_val("busy_illegal", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check_val({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    check_val({tag, "_tx_data"},  64'(tx_data),  64'd0);
    check_val({tag, "_par_we"},   64'(par_we),   64'd0);
    check_val({tag, "_par_addr"}, 64'(par_addr), 64'd0);
    check_val({tag, "_par_in"},   64'(par_in),   64'd0);
    check_val({tag, "_busy"},     64'(busy),     64'd0);
    check_val({tag, "_err"},      64'(err),      64'd0);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  b;
    int          k;
    int          gap;

    for (int i = 0; i < 16; i++) mdl_mem[i] = INIT[i];

    // Power-on reset
    #1 rst = 1'b0;
    #2 check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rx_ready_after_rst", 64'(rx_ready), 64'd1);
    check_val("busy_after_rst", 64'(busy), 64'd0);

    // Directed frames
    tx_mode = 0;
    do_write(8'h03, 32'h12345678, 0);
    do_read(8'h05, 0);
    tx_mode = 2;
    do_read(8'h05, 0);
    tx_mode = 1;
    do_read(8'h03, 1);
    do_illegal(8'h41);
    tx_mode = 0;
    do_status(1'b1);
    do_status(1'b0);
    do_write(8'h0A, 32'hCAFEBABE, 5);
    do_read(8'hF3, 0);
    do_read(8'h0A, 0);

    // Reset in the middle of a write frame
    send_byte(8'h57);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rx_ready_after_rst2", 64'(rx_ready), 64'd1);
    do_read(8'h02, 0);

    // Randomized frames
    for (int i = 0; i < 80; i++) begin
      k       = $urandom_range(0, 9);
      tx_mode = $urandom_range(0, 2);
      gap     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      a       = 8'($urandom);
      d       = $urandom;
      if (k < 3) begin
        do_write(a, d, gap);
      end else if (k < 6) begin
        do_read(a, gap);
      end else if (k < 8) begin
        do_status(1'($urandom_range(0, 1)));
      end else begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52 || b == 8'h53) b = 8'($urandom);
        do_illegal(b);
      end
    end

    idle_cycles(3);
    check_val("err_total", 64'(seen_err), 64'(exp_err));
    check_val("wr_q_final", 64'(exp_wr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
